// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the five-stage pipeline hazard controller:
// stage indices, sequencer state encoding and exception vector default.
package pipe_hazard_ctrl_pkg;

   localparam int NUM_STAGES = 5;
   localparam int PC_S       = 0;
   localparam int IFID_S     = 1;
   localparam int IDEX_S     = 2;
   localparam int EXMEM_S    = 3;
   localparam int MEMWB_S    = 4;

   typedef enum logic {
      NORMAL        = 1'b0,
      REDIRECT_WAIT = 1'b1
   } hz_state_t;

   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

   // Exception squashes every register downstream of the pc.
   localparam logic [NUM_STAGES-1:0] EXC_FLUSH = 5'b11110;

endpackage

// File: rtl/pipe_hazard_ctrl_div_timer.sv
// Multi-cycle divide occupancy counter: busy for DIV_CYCLES cycles after a
// start, with last flagging the final busy cycle and cancel aborting it.
module pipe_hazard_ctrl_div_timer #(
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic cancel,
   output logic busy,
   output logic last
);

   localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

   logic          busy_reg;
   logic [CW-1:0] cnt_reg;

   assign busy = busy_reg;
   assign last = busy_reg && (cnt_reg == CW'(DIV_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_reg <= 1'b0;
         cnt_reg  <= '0;
      end else if (cancel) begin
         busy_reg <= 1'b0;
         cnt_reg  <= '0;
      end else if (!busy_reg) begin
         // A start while already busy falls through to the counting branch.
         if (start) begin
            busy_reg <= 1'b1;
            cnt_reg  <= '0;
         end
      end else if (last) begin
         busy_reg <= 1'b0;
         cnt_reg  <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: prioritises memory
// waits, divides, load-use and fetch waits, and sequences exception redirects.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int          DIV_CYCLES = 32,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic        if_ack,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_w_reg_dst,
   input  logic        ex_div_start,
   input  logic        mem_req,
   input  logic        mem_ack,
   input  logic        mem_has_exception,
   output logic [4:0]  stall_o,
   output logic [4:0]  flush_o,
   output logic        pc_redirect,
   output logic [31:0] pc_redirect_addr,
   output logic        div_busy
);

   hz_state_t state_reg, state_next;

   logic mem_wait, div_wait, load_use, if_wait;
   logic exc_take, div_start, dt_busy, dt_last;
   logic any_src;
   logic [2:0] level;
   logic [NUM_STAGES-1:0] lvl_stall, lvl_flush, stall_vec, flush_vec;
   logic redirect;

   assign mem_wait = mem_req && !mem_ack;
   assign div_wait = dt_busy && !dt_last;
   assign load_use = ex_mem_read && (ex_w_reg_dst != 5'd0) &&
                     ((id_use_rs && (id_rs == ex_w_reg_dst)) ||
                      (id_use_rt && (id_rt == ex_w_reg_dst)));
   assign if_wait  = if_req && !if_ack;

   // An exception waits behind an outstanding data access, then is taken on its ack.
   assign exc_take  = (state_reg == NORMAL) && mem_has_exception && !mem_wait;
   assign div_start = (state_reg == NORMAL) && ex_div_start;

   pipe_hazard_ctrl_div_timer #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (div_start),
      .cancel (exc_take),
      .busy   (dt_busy),
      .last   (dt_last)
   );

   always_comb begin
      any_src = 1'b1;
      level   = 3'd0;
      if (mem_wait)      level = 3'(EXMEM_S);
      else if (div_wait) level = 3'(IDEX_S);
      else if (load_use) level = 3'(IFID_S);
      else if (if_wait)  level = 3'(PC_S);
      else               any_src = 1'b0;
   end

   // Everything up to the deepest stalled stage holds; the next one takes a bubble.
   for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_lvl
      assign lvl_stall[gi] = any_src && (3'(gi) <= level);
      assign lvl_flush[gi] = any_src && (3'(gi) == level + 3'd1);
   end

   always_ff @(posedge clk) begin
      if (!rst) state_reg <= NORMAL;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         NORMAL:        if (exc_take && if_wait) state_next = REDIRECT_WAIT;
         REDIRECT_WAIT: if (if_ack)              state_next = NORMAL;
         default:       state_next = NORMAL;
      endcase
   end

   always_comb begin
      stall_vec = '0;
      flush_vec = '0;
      redirect  = 1'b0;
      if (rst) begin
         case (state_reg)
            NORMAL: begin
               if (exc_take) begin
                  flush_vec       = EXC_FLUSH;
                  stall_vec[PC_S] = if_wait;
                  redirect        = !if_wait;
               end else begin
                  stall_vec = lvl_stall;
                  flush_vec = lvl_flush;
               end
            end
            REDIRECT_WAIT: begin
               flush_vec       = EXC_FLUSH;
               stall_vec[PC_S] = !if_ack;
               redirect        = if_ack;
            end
            default: ;
         endcase
      end
   end

   assign stall_o          = stall_vec;
   assign flush_o          = flush_vec;
   assign pc_redirect      = redirect;
   assign pc_redirect_addr = EXC_VECTOR;
   assign div_busy         = rst && dt_busy;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random
// traffic, checked against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

   localparam int DIV_CYCLES = 4;
   localparam logic [31:0] EXC_ADDR = 32'hBFC0_0380;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_ack;
   logic [4:0]  id_rs, id_rt;
   logic        id_use_rs, id_use_rt;
   logic        ex_mem_read;
   logic [4:0]  ex_w_reg_dst;
   logic        ex_div_start;
   logic        mem_req, mem_ack, mem_has_exception;
   logic [4:0]  stall_o, flush_o;
   logic        pc_redirect;
   logic [31:0] pc_redirect_addr;
   logic        div_busy;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .DIV_CYCLES (DIV_CYCLES),
      .EXC_VECTOR (EXC_ADDR)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .if_req            (if_req),
      .if_ack            (if_ack),
      .id_rs             (id_rs),
      .id_rt             (id_rt),
      .id_use_rs         (id_use_rs),
      .id_use_rt         (id_use_rt),
      .ex_mem_read       (ex_mem_read),
      .ex_w_reg_dst      (ex_w_reg_dst),
      .ex_div_start      (ex_div_start),
      .mem_req           (mem_req),
      .mem_ack           (mem_ack),
      .mem_has_exception (mem_has_exception),
      .stall_o           (stall_o),
      .flush_o           (flush_o),
      .pc_redirect       (pc_redirect),
      .pc_redirect_addr  (pc_redirect_addr),
      .div_busy          (div_busy)
   );

   typedef struct {
      logic [4:0] stall;
      logic [4:0] flush;
      logic       redir;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   txn    = 0;

   // Reference model: waiting for a redirect, and cycles of divide occupancy left.
   bit m_rw = 0;
   int m_left = 0;
   bit n_rw;
   int n_left;

   task automatic model_eval(output exp_t e);
      bit mw, dw, lu, iw, exc;
      int lvl;
      e.stall = '0; e.flush = '0; e.redir = 0; e.busy = 0;
      n_rw = m_rw;
      n_left = (m_left > 0) ? m_left - 1 : 0;
      if (!rst) begin
         n_rw = 0;
         n_left = 0;
      end else if (m_rw) begin
         e.busy  = (m_left > 0);
         e.flush = 5'b11110;
         e.stall = if_ack ? 5'b00000 : 5'b00001;
         e.redir = if_ack;
         if (if_ack) n_rw = 0;
      end else begin
         e.busy = (m_left > 0);
         mw = mem_req && !mem_ack;
         dw = (m_left > 1);
         lu = ex_mem_read && ex_w_reg_dst != 0 &&
              ((id_use_rs && id_rs == ex_w_reg_dst) || (id_use_rt && id_rt == ex_w_reg_dst));
         iw = if_req && !if_ack;
         exc = mem_has_exception && !mw;
         if (exc) begin
            e.flush = 5'b11110;
            e.stall = iw ? 5'b00001 : 5'b00000;
            e.redir = !iw;
            n_rw = iw;
            n_left = 0;
         end else begin
            lvl = -1;
            if (iw) lvl = 0;
            if (lu) lvl = 1;
            if (dw) lvl = 2;
            if (mw) lvl = 3;
            if (lvl >= 0) begin
               e.stall = 5'((1 << (lvl + 1)) - 1);
               e.flush = 5'(1 << (lvl + 1));
            end
            if (m_left == 0 && ex_div_start) n_left = DIV_CYCLES;
         end
      end
   endtask

   task automatic step();
      exp_t e;
      model_eval(e);
      exp_q.push_back(e);
      @(posedge clk);
      m_rw = n_rw;
      m_left = n_left;
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1; if_req = 0; if_ack = 0; id_rs = 0; id_rt = 0;
      id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0; ex_w_reg_dst = 0;
      ex_div_start = 0; mem_req = 0; mem_ack = 0; mem_has_exception = 0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s txn=%0d actual=%h required=%h", name, txn, act, req);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare mid-cycle.
   exp_t mon_e;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         txn++;
         $display("txn %0d rst=%b stall=%b flush=%b redir=%b busy=%b", txn, rst,
                  stall_o, flush_o, pc_redirect, div_busy);
         check("stall", 32'(stall_o), 32'(mon_e.stall));
         check("flush", 32'(flush_o), 32'(mon_e.flush));
         check("redirect", 32'(pc_redirect), 32'(mon_e.redir));
         check("div_busy", 32'(div_busy), 32'(mon_e.busy));
         if (pc_redirect) check("redirect_addr", pc_redirect_addr, EXC_ADDR);
      end
   end

   initial begin
      idle_inputs();
      rst = 0;
      @(posedge clk); #1;
      step(); step();
      rst = 1;
      step();

      // Load-use hit, then the same with r0 as destination.
      ex_mem_read = 1; ex_w_reg_dst = 5; id_rs = 5; id_use_rs = 1;
      step();
      ex_w_reg_dst = 0;
      step();
      idle_inputs();
      step();

      // Divide with a second start while busy.
      ex_div_start = 1; step();
      ex_div_start = 0; step();
      ex_div_start = 1; step();
      ex_div_start = 0;
      repeat (4) step();

      // Memory wait overriding load-use and fetch wait, then ack.
      mem_req = 1; if_req = 1;
      ex_mem_read = 1; ex_w_reg_dst = 7; id_rt = 7; id_use_rt = 1;
      repeat (5) step();
      mem_ack = 1; step();
      idle_inputs(); step();

      // Exception mid-divide with no waits.
      ex_div_start = 1; step();
      ex_div_start = 0; step();
      mem_has_exception = 1; step();
      mem_has_exception = 0; step(); step();

      // Exception during fetch wait; ack arrives after 3 cycles.
      if_req = 1; mem_has_exception = 1; step();
      mem_has_exception = 0; step(); step(); step();
      if_ack = 1; step();
      idle_inputs(); step();

      // Exception deferred by a memory wait, then reset in REDIRECT_WAIT.
      mem_req = 1; mem_has_exception = 1; if_req = 1;
      step(); step();
      mem_ack = 1; step();
      mem_ack = 0; mem_req = 0; mem_has_exception = 0;
      step();
      rst = 0; step();
      rst = 1; if_ack = 1; step();
      idle_inputs(); step();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         rst               = ($urandom_range(0, 63) != 0);
         if_req            = $urandom_range(0, 1);
         if_ack            = ($urandom_range(0, 2) == 0);
         id_rs             = 5'($urandom_range(0, 3));
         id_rt             = 5'($urandom_range(0, 3));
         id_use_rs         = $urandom_range(0, 1);
         id_use_rt         = $urandom_range(0, 1);
         ex_mem_read       = $urandom_range(0, 1);
         ex_w_reg_dst      = 5'($urandom_range(0, 3));
         ex_div_start      = ($urandom_range(0, 5) == 0);
         mem_req           = ($urandom_range(0, 3) == 0);
         mem_ack           = ($urandom_range(0, 2) == 0);
         mem_has_exception = ($urandom_range(0, 15) == 0);
         step();
      end

      idle_inputs();
      @(negedge clk); #1;
      check("queue_drain", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
